ktms_afu_cap_tbl: RTL and testbench
===================================

# ktms_afu_cap_tbl

Per-context capability table that receives the capability-update stream (`cap_wr_v/ctxt/d`) produced by the context-control register block and answers capability lookups from the command-processing pipeline. It is the storage/consumer end of that update interface. After reset it zero-initialises every entry, then serves one lookup per cycle through a valid/ready response stage. A same-cycle write is forwarded into the response.

## Interface

Parameters:
- `ctxtid_width`, 10: context id width including the trailing odd-parity bit (LSB). The table has 2^(ctxtid_width-1) entries.
- `ctxtcap_width`, 7: capability field width.
- `tag_width`, 8: lookup tag carried unchanged to the response.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous reset, active-low.
- `i_cap_wr_v`  in  1  capability write strobe. No ready signal; the block must always accept it.
- `i_cap_wr_ctxt`  in  ctxtid_width  context id of the write, with parity.
- `i_cap_wr_d`  in  ctxtcap_width  new capability value.
- `i_lkup_v`  in  1  lookup request valid.
- `o_lkup_r`  out  1  lookup request ready.
- `i_lkup_ctxt`  in  ctxtid_width  context id of the lookup, with parity.
- `i_lkup_tag`  in  tag_width  lookup tag.
- `o_rsp_v`  out  1  response valid.
- `i_rsp_r`  in  1  response ready.
- `o_rsp_tag`  out  tag_width  tag of the request being answered.
- `o_rsp_cap`  out  ctxtcap_width  capability value.
- `o_rsp_perr`  out  1  set when the lookup context id had bad parity; `o_rsp_cap` is forced to 0.
- `o_init_done`  out  1  initialisation sweep complete.
- `o_perror`  out  2  sticky errors: [0] context-id parity error (write or lookup), [1] write dropped during INIT.

## Operation

- **Storage:** one memory with 2^(ctxtid_width-1) words of ctxtcap_width bits. It has one write port and one read port. The address is `ctxt[0:ctxtid_width-2]`.
- **FSM `INIT`:**
  - Entered on reset. `init_cnt` starts at 0 and writes 0 to address `init_cnt` each cycle.
  - When `init_cnt` reaches all-ones, the block moves to `RUN`.
  - `o_lkup_r` is 0 throughout INIT.
  - Any `i_cap_wr_v` during INIT is dropped and sets `o_perror[1]`.
- **FSM `RUN`:** terminal state; left only by reset.
- **Capability writes (RUN):** when `i_cap_wr_v`=1, write `i_cap_wr_d` to the entry in the same cycle.
  - A write of 0 clears the entry. Context add/remove arrives as a zero write.
- **Lookup accept:** `acc = i_lkup_v & o_lkup_r`.
  - `o_lkup_r = init_done & (~o_rsp_v | i_rsp_r)`.
  - On `acc`, the memory is read and the tag and parity-error flag are registered.
- **Response hold:** while `o_rsp_v & ~i_rsp_r`, the response fields hold stable. The memory read enable is low, so the read data holds.
  - The response reflects the table at the accept cycle. Later writes to the same context do not alter a stalled response.
- **Write/lookup bypass:** if `acc` and `i_cap_wr_v` occur in the same cycle with equal addresses, the response returns `i_cap_wr_d`. The memory is still written.
- **Parity:** odd parity over `ctxt[0:ctxtid_width-2]` plus the parity bit.
  - Bad lookup parity: the response is still issued with `o_rsp_perr`=1 and `o_rsp_cap`=0, and `o_perror[0]` is set.
  - Bad write parity: the write is dropped and `o_perror[0]` is set.
- **Sticky errors:** `o_perror` bits clear only on reset.

## Timing

- **Reset values:** `o_lkup_r`=0, `o_rsp_v`=0, `o_rsp_tag`=0, `o_rsp_cap`=0, `o_rsp_perr`=0, `o_init_done`=0, `o_perror`=0.
- **INIT length:** cycle 0 is the first cycle with `reset`=1. The sweep writes addresses 0..2^(ctxtid_width-1)-1 on cycles 0..N-1. `o_init_done` and `o_lkup_r` rise on cycle N (512 for the default).
- **Lookup latency:** accept on cycle t gives `o_rsp_v`=1 on cycle t+1.
- **Throughput:** sustained one lookup per cycle while `i_rsp_r`=1.
- **Write-to-lookup:** a write on cycle t is visible to a lookup accepted on cycle t (via bypass) or later.
- **Reset mid-operation:** an in-flight response is discarded, `o_rsp_v` goes to 0 in the next cycle, and the INIT sweep restarts from 0.

## Configuration

- `KTMS_CAP_TBL_PARCHK_EN` defined: parity checking as above.
- Undefined:
  - The parity bit is ignored.
  - `o_rsp_perr` and `o_perror[0]` are tied 0.
  - All writes in RUN are accepted.
  - Lookups always return table data.

## Test plan

- **Reset/init:** release reset. `o_lkup_r`=0 for cycles 0..511, `o_init_done`=1 at cycle 512. Lookup ctxt 5 then returns cap 0.
- **Write then read:** write ctxt 3 = 7'h45 on cycle t, lookup ctxt 3 with tag 8'hA1 on cycle t+1. Response on t+2 is cap 7'h45, tag 8'hA1.
- **Same-cycle bypass:** ctxt 9 holds 7'h01; write 7'h7F and lookup ctxt 9 in the same cycle. Response is 7'h7F. A later lookup also returns 7'h7F.
- **Backpressure:** hold `i_rsp_r`=0 with a response for ctxt 2 (7'h10) pending, then write ctxt 2 = 7'h20. The response stays 7'h10 with tag stable and `o_lkup_r`=0. After `i_rsp_r`=1, the next lookup returns 7'h20.
- **Parity (macro on):** lookup with a flipped parity bit returns `o_rsp_perr`=1, cap 0, and `o_perror[0]` stays 1. A bad-parity write leaves the entry unchanged.
- **Write during INIT:** `i_cap_wr_v`=1 at cycle 100 sets `o_perror[1]`. After INIT the entry reads 0.

Source files
------------

// File: rtl/ktms_afu_cap_tbl.sv
// ktms_afu_cap_tbl: per-context capability table.
// Consumes the cap_wr update stream and answers one lookup per cycle
// through a valid/ready response stage; a same-cycle write to the looked-up
// context is forwarded into the response. Zero-initialises every entry after
// reset before accepting lookups.
// Optional feature macro: KTMS_CAP_TBL_PARCHK_EN (odd-parity checking of
// context ids on writes and lookups).
module ktms_afu_cap_tbl #(
  parameter int ctxtid_width  = 10,
  parameter int ctxtcap_width = 7,
  parameter int tag_width     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_cap_wr_v,
  input  logic [ctxtid_width-1:0]  i_cap_wr_ctxt,
  input  logic [ctxtcap_width-1:0] i_cap_wr_d,
  input  logic                     i_lkup_v,
  output logic                     o_lkup_r,
  input  logic [ctxtid_width-1:0]  i_lkup_ctxt,
  input  logic [tag_width-1:0]     i_lkup_tag,
  output logic                     o_rsp_v,
  input  logic                     i_rsp_r,
  output logic [tag_width-1:0]     o_rsp_tag,
  output logic [ctxtcap_width-1:0] o_rsp_cap,
  output logic                     o_rsp_perr,
  output logic                     o_init_done,
  output logic [1:0]               o_perror
);

  localparam int aw    = ctxtid_width - 1;
  localparam int depth = 1 << aw;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                   state;
  logic [aw-1:0]            init_cnt;
  logic [ctxtcap_width-1:0] mem [depth];

  logic [aw-1:0]            wr_addr;
  logic [aw-1:0]            lk_addr;
  logic                     wr_par_ok;
  logic                     lk_par_ok;
  logic                     init_done;
  logic                     acc;
  logic                     wr_run;
  logic                     wr_ok;
  logic                     bypass;
  logic                     par_evt;

  logic                     mem_we;
  logic [aw-1:0]            mem_wa;
  logic [ctxtcap_width-1:0] mem_wd;

  logic [ctxtcap_width-1:0] rd_q;
  logic                     rsp_v_q;
  logic [tag_width-1:0]     rsp_tag_q;
  logic                     rsp_perr_q;
  logic                     byp_q;
  logic [ctxtcap_width-1:0] byp_d_q;
  logic [1:0]               perror_q;

  // The parity bit is the LSB; the table index is everything above it.
  assign wr_addr = i_cap_wr_ctxt[ctxtid_width-1:1];
  assign lk_addr = i_lkup_ctxt[ctxtid_width-1:1];

`ifdef KTMS_CAP_TBL_PARCHK_EN
  assign wr_par_ok = ^i_cap_wr_ctxt;
  assign lk_par_ok = ^i_lkup_ctxt;
`else
  logic unused_par;
  assign wr_par_ok  = 1'b1;
  assign lk_par_ok  = 1'b1;
  assign unused_par = i_cap_wr_ctxt[0] ^ i_lkup_ctxt[0];
`endif

  assign init_done = (state == ST_RUN);
  assign o_lkup_r  = init_done & (~rsp_v_q | i_rsp_r);
  assign acc       = i_lkup_v & o_lkup_r;
  assign wr_run    = i_cap_wr_v & init_done;
  assign wr_ok     = wr_run & wr_par_ok;
  assign bypass    = acc & wr_ok & (wr_addr == lk_addr);
  assign par_evt   = (wr_run & ~wr_par_ok) | (acc & ~lk_par_ok);

  // Init FSM: sweep every address once after reset, then serve forever.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + aw'(1);
          if (init_cnt == '1) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Single write port shared between the init sweep and capability updates.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (reset && state == ST_INIT) begin
      mem_we = 1'b1;
      mem_wa = init_cnt;
    end else if (reset && wr_ok) begin
      mem_we = 1'b1;
      mem_wa = wr_addr;
      mem_wd = i_cap_wr_d;
    end
  end

  // Table storage write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read port: enabled only on accept so a stalled response keeps its data.
  always_ff @(posedge clk) begin
    if (!reset) rd_q <= '0;
    else if (acc) rd_q <= mem[lk_addr];
  end

  // Response stage: load on accept, drop on handshake, otherwise hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_v_q    <= 1'b0;
      rsp_tag_q  <= '0;
      rsp_perr_q <= 1'b0;
      byp_q      <= 1'b0;
      byp_d_q    <= '0;
    end else if (acc) begin
      rsp_v_q    <= 1'b1;
      rsp_tag_q  <= i_lkup_tag;
      rsp_perr_q <= ~lk_par_ok;
      byp_q      <= bypass;
      byp_d_q    <= i_cap_wr_d;
    end else if (i_rsp_r) begin
      rsp_v_q    <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perror_q <= '0;
    end else begin
      if (i_cap_wr_v && !init_done) perror_q[1] <= 1'b1;
      if (par_evt) perror_q[0] <= 1'b1;
    end
  end

  // Forwarded write data wins over the (older) memory read; bad parity forces 0.
  always_comb begin
    o_rsp_cap = '0;
    if (!rsp_perr_q) o_rsp_cap = byp_q ? byp_d_q : rd_q;
  end

  assign o_rsp_v     = rsp_v_q;
  assign o_rsp_tag   = rsp_tag_q;
  assign o_rsp_perr  = rsp_perr_q;
  assign o_init_done = init_done;
  assign o_perror    = perror_q;

endmodule

// File: tb/tb_ktms_afu_cap_tbl.sv
// Self-checking bench for ktms_afu_cap_tbl (default parameters).
// Expected responses are queued when a lookup is driven and compared when the
// response handshake completes. Parity expectations follow KTMS_CAP_TBL_PARCHK_EN.
module tb_ktms_afu_cap_tbl;

`ifdef KTMS_CAP_TBL_PARCHK_EN
  localparam bit par_en = 1'b1;
`else
  localparam bit par_en = 1'b0;
`endif
  localparam int n_ent = 512;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_cap_wr_v;
  logic [9:0] i_cap_wr_ctxt;
  logic [6:0] i_cap_wr_d;
  logic       i_lkup_v;
  logic       o_lkup_r;
  logic [9:0] i_lkup_ctxt;
  logic [7:0] i_lkup_tag;
  logic       o_rsp_v;
  logic       i_rsp_r;
  logic [7:0] o_rsp_tag;
  logic [6:0] o_rsp_cap;
  logic       o_rsp_perr;
  logic       o_init_done;
  logic [1:0] o_perror;

  typedef struct {
    logic [7:0] tag;
    logic [6:0] cap;
    logic       perr;
  } exp_t;

  exp_t       sb[$];
  exp_t       got_e;
  logic [6:0] model [n_ent];
  int         n_chk = 0;
  int         n_fail = 0;

  ktms_afu_cap_tbl #(
    .ctxtid_width (10),
    .ctxtcap_width(7),
    .tag_width    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_cap_wr_v   (i_cap_wr_v),
    .i_cap_wr_ctxt(i_cap_wr_ctxt),
    .i_cap_wr_d   (i_cap_wr_d),
    .i_lkup_v     (i_lkup_v),
    .o_lkup_r     (o_lkup_r),
    .i_lkup_ctxt  (i_lkup_ctxt),
    .i_lkup_tag   (i_lkup_tag),
    .o_rsp_v      (o_rsp_v),
    .i_rsp_r      (i_rsp_r),
    .o_rsp_tag    (o_rsp_tag),
    .o_rsp_cap    (o_rsp_cap),
    .o_rsp_perr   (o_rsp_perr),
    .o_init_done  (o_init_done),
    .o_perror     (o_perror)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mk_ctxt(input logic [8:0] a, input bit bad);
    return {a, ~(^a) ^ bad};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One RUN-mode cycle of optional write and optional lookup.
  task automatic drv(input bit wv, input logic [8:0] wa, input logic [6:0] wd, input bit wbad,
                     input bit lv, input logic [8:0] la, input logic [7:0] lt, input bit lbad);
    exp_t e;
    bit   wr_ok;
    wr_ok = wv && !(par_en && wbad);
    if (lv) begin
      chk("lkup_r", o_lkup_r, 1);
      e.tag  = lt;
      e.perr = par_en && lbad;
      if (e.perr) e.cap = 7'h00;
      else e.cap = (wr_ok && wa == la) ? wd : model[la];
      sb.push_back(e);
    end
    i_cap_wr_v    = wv;
    i_cap_wr_ctxt = mk_ctxt(wa, wbad);
    i_cap_wr_d    = wd;
    i_lkup_v      = lv;
    i_lkup_ctxt   = mk_ctxt(la, lbad);
    i_lkup_tag    = lt;
    step();
    if (wr_ok) model[wa] = wd;
    i_cap_wr_v = 1'b0;
    i_lkup_v   = 1'b0;
    if (lv) chk("rsp_latency", o_rsp_v, 1);
  endtask

  task automatic run_init(input bit inject_wr);
    int bad = 0;
    reset = 1'b1;
    for (int c = 0; c < n_ent; c++) begin
      if (o_init_done || o_lkup_r) bad++;
      if (inject_wr && c == 100) begin
        i_cap_wr_v    = 1'b1;
        i_cap_wr_ctxt = mk_ctxt(9'd7, 1'b0);
        i_cap_wr_d    = 7'h33;
      end
      if (c == 101) i_cap_wr_v = 1'b0;
      step();
    end
    chk("init_busy_cycles", bad, 0);
    chk("init_done_512", o_init_done, 1);
    chk("lkup_r_512", o_lkup_r, 1);
    for (int i = 0; i < n_ent; i++) model[i] = 7'h00;
  endtask

  // Scoreboard: compare on every completed response handshake.
  always @(negedge clk) begin
    if (reset && o_rsp_v && i_rsp_r) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        got_e = sb.pop_front();
        chk("rsp_tag", o_rsp_tag, got_e.tag);
        chk("rsp_cap", o_rsp_cap, got_e.cap);
        chk("rsp_perr", o_rsp_perr, got_e.perr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] held_tag;
    reset         = 1'b0;
    i_cap_wr_v    = 1'b0;
    i_cap_wr_ctxt = '0;
    i_cap_wr_d    = '0;
    i_lkup_v      = 1'b0;
    i_lkup_ctxt   = '0;
    i_lkup_tag    = '0;
    i_rsp_r       = 1'b1;
    repeat (3) step();

    chk("rst_rsp_v", o_rsp_v, 0);
    chk("rst_rsp_fields", {o_rsp_tag, o_rsp_cap, o_rsp_perr}, 0);
    chk("rst_init_lkup_r", {o_init_done, o_lkup_r}, 0);
    chk("rst_perror", o_perror, 0);

    run_init(1'b1);
    chk("init_wr_perror", o_perror, 2'b10);

    drv(0, 0, 0, 0, 1, 9'd5, 8'h05, 0);
    drv(0, 0, 0, 0, 1, 9'd7, 8'h07, 0);

    drv(1, 9'd3, 7'h45, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 9'd3, 8'hA1, 0);

    drv(1, 9'd9, 7'h01, 0, 0, 0, 0, 0);
    drv(1, 9'd9, 7'h7F, 0, 1, 9'd9, 8'hB0, 0);
    drv(0, 0, 0, 0, 1, 9'd9, 8'hB1, 0);

    drv(1, 9'd2, 7'h10, 0, 0, 0, 0, 0);
    i_rsp_r = 1'b0;
    drv(0, 0, 0, 0, 1, 9'd2, 8'h5A, 0);
    held_tag = 8'h5A;
    drv(1, 9'd2, 7'h20, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_rsp_v", o_rsp_v, 1);
      chk("hold_cap", o_rsp_cap, 7'h10);
      chk("hold_tag", o_rsp_tag, held_tag);
      chk("hold_lkup_r", o_lkup_r, 0);
      step();
    end
    i_rsp_r = 1'b1;
    step();
    drv(0, 0, 0, 0, 1, 9'd2, 8'h5B, 0);

    drv(0, 0, 0, 0, 1, 9'd9, 8'hC3, 1);
    drv(1, 9'd3, 7'h55, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 9'd3, 8'hC4, 0);
    step();
    chk("perror0_sticky", o_perror[0], par_en);
    chk("perror1_sticky", o_perror[1], 1);

    for (int i = 0; i < 60; i++) begin
      drv(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 7'($urandom), 0,
          1'($urandom_range(0, 3) != 0), 9'($urandom_range(0, 15)), 8'(i + 16), 0);
    end
    repeat (2) step();
    chk("sb_drained_run", sb.size(), 0);

    i_rsp_r     = 1'b0;
    i_lkup_v    = 1'b1;
    i_lkup_ctxt = mk_ctxt(9'd4, 1'b0);
    i_lkup_tag  = 8'h77;
    step();
    i_lkup_v = 1'b0;
    chk("midrst_inflight", o_rsp_v, 1);
    reset = 1'b0;
    step();
    chk("midrst_rsp_v", o_rsp_v, 0);
    chk("midrst_state", {o_init_done, o_lkup_r, o_perror}, 0);
    run_init(1'b0);
    i_rsp_r = 1'b1;
    drv(0, 0, 0, 0, 1, 9'd3, 8'hE3, 0);
    drv(0, 0, 0, 0, 1, 9'd9, 8'hE9, 0);
    repeat (2) step();
    chk("sb_drained_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
